// File: rtl/bicubic_pkg.sv
// Shared defaults for the bicubic accumulate/normalise stage and its
// statistics counter helper.
package bicubic_pkg;

  localparam int DEF_CH        = 3;
  localparam int DEF_A_W       = 40;
  localparam int DEF_B_W       = 38;
  localparam int DEF_C_W       = 28;
  localparam int DEF_D_W       = 18;
  localparam int DEF_SH_B      = 8;
  localparam int DEF_SH_C      = 16;
  localparam int DEF_SH_D      = 24;
  localparam int DEF_ACC_W     = 46;
  localparam int DEF_FRAC      = 24;
  localparam int DEF_OUT_W     = 8;
  localparam int DEF_ALIGN_DLY = 4;

  localparam int STAT_W = 16;

  // Next value of a sticky event counter: a clear beats a hit, and a full
  // counter stays at all-ones.
  function automatic logic [STAT_W-1:0] stat_next(input logic [STAT_W-1:0] cnt,
                                                  input logic              hit,
                                                  input logic              clr);
    if (clr) return '0;
    if (hit && (cnt != '1)) return cnt + STAT_W'(1);
    return cnt;
  endfunction

endpackage

// File: rtl/bicubic_mac_round_if.sv
// Input and output stream of the accumulate/normalise stage: packed
// per-channel terms in, per-channel pixels and flags out.
interface bicubic_mac_round_if import bicubic_pkg::*; #(
  parameter int CH    = DEF_CH,
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int C_W   = DEF_C_W,
  parameter int D_W   = DEF_D_W,
  parameter int OUT_W = DEF_OUT_W
);

  logic                in_valid;
  logic                in_ready;
  logic [CH*A_W-1:0]   in_a;
  logic [CH*B_W-1:0]   in_b;
  logic [CH*C_W-1:0]   in_c;
  logic [CH*D_W-1:0]   in_d;
  logic                in_round;

  logic                out_valid;
  logic                out_ready;
  logic [CH*OUT_W-1:0] out_data;
  logic [CH-1:0]       out_clip;
  logic [CH-1:0]       out_sat;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, in_a, in_b, in_c, in_d, in_round, out_ready,
    input  in_ready, out_valid, out_data, out_clip, out_sat
  );

  // The stage itself
  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, in_round, out_ready,
    output in_ready, out_valid, out_data, out_clip, out_sat
  );

endinterface

// File: rtl/bicubic_chan_dp.sv
// Single-channel four-stage datapath: sum, clamp, round, normalise with
// saturation. All stages advance together on i_en.
module bicubic_chan_dp import bicubic_pkg::*; #(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int C_W   = DEF_C_W,
  parameter int D_W   = DEF_D_W,
  parameter int SH_B  = DEF_SH_B,
  parameter int SH_C  = DEF_SH_C,
  parameter int SH_D  = DEF_SH_D,
  parameter int ACC_W = DEF_ACC_W,
  parameter int FRAC  = DEF_FRAC,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [A_W-1:0]   i_a,
  input  logic [B_W-1:0]   i_b,
  input  logic [C_W-1:0]   i_c,
  input  logic [D_W-1:0]   i_d,
  input  logic             i_round,
  output logic [OUT_W-1:0] o_q,
  output logic             o_clip,
  output logic             o_sat
);

  // One guard bit so that neither the negative sum nor the rounded value
  // can wrap.
  localparam int             S_W   = ACC_W + 1;
  localparam logic [S_W-1:0] RND   = S_W'(1) << (FRAC - 1);
  localparam logic [S_W-1:0] Q_MAX = (S_W'(1) << OUT_W) - S_W'(1);

  logic [S_W-1:0]   w_pos, w_neg;
  logic [ACC_W-1:0] w_diff;
  logic             w_clip;
  logic [S_W-1:0]   w_r;
  logic [S_W-1:0]   w_q;
  logic             w_sat;

  logic [S_W-1:0]   r_pos, r_neg;
  logic             r_rnd1;
  logic [ACC_W-1:0] r_diff;
  logic             r_clip2, r_rnd2;
  logic [S_W-1:0]   r_r;
  logic             r_clip3;

  assign w_pos  = S_W'(i_a) + (S_W'(i_c) << SH_C);
  assign w_neg  = (S_W'(i_b) << SH_B) + (S_W'(i_d) << SH_D);
  assign w_clip = r_pos < r_neg;
  assign w_diff = w_clip ? '0 : ACC_W'(r_pos - r_neg);
  assign w_r    = S_W'(r_diff) + (r_rnd2 ? RND : '0);
  assign w_q    = r_r >> FRAC;
  assign w_sat  = w_q > Q_MAX;

  // S1..S4 pipeline registers, frozen together when the stream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos   <= '0;
      r_neg   <= '0;
      r_rnd1  <= 1'b0;
      r_diff  <= '0;
      r_clip2 <= 1'b0;
      r_rnd2  <= 1'b0;
      r_r     <= '0;
      r_clip3 <= 1'b0;
      o_q     <= '0;
      o_clip  <= 1'b0;
      o_sat   <= 1'b0;
    end else if (i_en) begin
      // NOTE: non-blocking assignments let every stage read its predecessor's
      // old value, which is what makes this a shift rather than a wire.
      r_pos   <= w_pos;
      r_neg   <= w_neg;
      r_rnd1  <= i_round;
      r_diff  <= w_diff;
      r_clip2 <= w_clip;
      r_rnd2  <= r_rnd1;
      r_r     <= w_r;
      r_clip3 <= r_clip2;
      o_q     <= w_sat ? '1 : w_q[OUT_W-1:0];
      o_clip  <= r_clip3;
      o_sat   <= w_sat;
    end
  end

endmodule

// File: rtl/bicubic_mac_round.sv
// Final accumulate/normalise stage of the bicubic interpolator: CH channel
// datapaths in lockstep, valid chain, alignment delay, backpressure and
// clip/saturate event counters.
module bicubic_mac_round import bicubic_pkg::*; #(
  parameter int CH        = DEF_CH,
  parameter int A_W       = DEF_A_W,
  parameter int B_W       = DEF_B_W,
  parameter int C_W       = DEF_C_W,
  parameter int D_W       = DEF_D_W,
  parameter int SH_B      = DEF_SH_B,
  parameter int SH_C      = DEF_SH_C,
  parameter int SH_D      = DEF_SH_D,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAC      = DEF_FRAC,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int ALIGN_DLY = DEF_ALIGN_DLY
) (
  input  logic                clk,
  input  logic                rst_n,
  bicubic_mac_round_if.slave  bus,
  input  logic                clr_stats,
  output logic [STAT_W-1:0]   clip_cnt,
  output logic [STAT_W-1:0]   sat_cnt
);

  localparam int NST = 4 + ALIGN_DLY;

  typedef struct packed {
    logic [CH*OUT_W-1:0] data;
    logic [CH-1:0]       clip;
    logic [CH-1:0]       sat;
  } beat_t;

  logic                w_en;
  logic                w_fire;
  logic [NST-1:0]      r_vld;
  logic [CH*OUT_W-1:0] w_q;
  logic [CH-1:0]       w_clip, w_sat;
  beat_t               w_s4, w_out;
  logic [STAT_W-1:0]   r_clip_cnt, r_sat_cnt;

  // The whole pipeline moves as one: any stall at the output freezes it.
  assign w_en          = !r_vld[NST-1] || bus.out_ready;
  assign w_fire        = r_vld[NST-1] && bus.out_ready;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_vld[NST-1];

  // Valid chain; empty slots travel as zeros so they never count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld <= '0;
    else if (w_en) r_vld <= {r_vld[NST-2:0], bus.in_valid};
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    bicubic_chan_dp #(
      .A_W(A_W), .B_W(B_W), .C_W(C_W), .D_W(D_W),
      .SH_B(SH_B), .SH_C(SH_C), .SH_D(SH_D),
      .ACC_W(ACC_W), .FRAC(FRAC), .OUT_W(OUT_W)
    ) u_dp (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_en),
      .i_a    (bus.in_a[g*A_W +: A_W]),
      .i_b    (bus.in_b[g*B_W +: B_W]),
      .i_c    (bus.in_c[g*C_W +: C_W]),
      .i_d    (bus.in_d[g*D_W +: D_W]),
      .i_round(bus.in_round),
      .o_q    (w_q[g*OUT_W +: OUT_W]),
      .o_clip (w_clip[g]),
      .o_sat  (w_sat[g])
    );
  end

  assign w_s4 = '{data: w_q, clip: w_clip, sat: w_sat};

  if (ALIGN_DLY == 0) begin : g_no_dly
    assign w_out = w_s4;
  end else begin : g_dly
    beat_t r_dly [ALIGN_DLY];

    // Alignment delay line for data and flags
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: this small delay line is reset on purpose: its last entry is
        // the visible output, which must read zero straight out of reset.
        for (int k = 0; k < ALIGN_DLY; k++) r_dly[k] <= '0;
      end else if (w_en) begin
        r_dly[0] <= w_s4;
        for (int k = 1; k < ALIGN_DLY; k++) r_dly[k] <= r_dly[k-1];
      end
    end

    assign w_out = r_dly[ALIGN_DLY-1];
  end

  assign bus.out_data = w_out.data;
  assign bus.out_clip = w_out.clip;
  assign bus.out_sat  = w_out.sat;

  // Event counters: one count per accepted beat carrying any flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clip_cnt <= '0;
      r_sat_cnt  <= '0;
    end else begin
      r_clip_cnt <= stat_next(r_clip_cnt, w_fire && (|w_out.clip), clr_stats);
      r_sat_cnt  <= stat_next(r_sat_cnt,  w_fire && (|w_out.sat),  clr_stats);
    end
  end

  assign clip_cnt = r_clip_cnt;
  assign sat_cnt  = r_sat_cnt;

endmodule

// File: tb/tb_bicubic_mac_round.sv
// Self-checking bench for bicubic_mac_round: directed corner beats, counter
// saturation and clear, a randomized backpressured stream against a
// behavioural model, and reset with beats in flight.
module tb_bicubic_mac_round;
  import bicubic_pkg::*;

  localparam int CH    = DEF_CH;
  localparam int A_W   = DEF_A_W;
  localparam int B_W   = DEF_B_W;
  localparam int C_W   = DEF_C_W;
  localparam int D_W   = DEF_D_W;
  localparam int OUT_W = DEF_OUT_W;
  localparam int LAT   = 4 + DEF_ALIGN_DLY;

  typedef struct packed {
    logic [CH*A_W-1:0] a;
    logic [CH*B_W-1:0] b;
    logic [CH*C_W-1:0] c;
    logic [CH*D_W-1:0] d;
    logic              rnd;
  } beat_t;

  typedef struct packed {
    logic [CH*OUT_W-1:0] data;
    logic [CH-1:0]       clip;
    logic [CH-1:0]       sat;
  } res_t;

  logic              clk;
  logic              rst_n;
  logic              clr_stats;
  logic [STAT_W-1:0] clip_cnt;
  logic [STAT_W-1:0] sat_cnt;
  int                errors = 0;
  int                checks = 0;

  bicubic_mac_round_if #(
    .CH(CH), .A_W(A_W), .B_W(B_W), .C_W(C_W), .D_W(D_W), .OUT_W(OUT_W)
  ) bus ();

  bicubic_mac_round dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr_stats(clr_stats),
    .clip_cnt (clip_cnt),
    .sat_cnt  (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: exact sums, clamp, optional half-LSB, divide, cap.
  function automatic res_t model(input beat_t bt);
    res_t r;
    longint unsigned a, b, c, d, pos, neg, val, q, qmax;
    r    = '0;
    qmax = (64'd1 << OUT_W) - 64'd1;
    for (int ch = 0; ch < CH; ch++) begin
      a   = 64'(bt.a[ch*A_W +: A_W]);
      b   = 64'(bt.b[ch*B_W +: B_W]);
      c   = 64'(bt.c[ch*C_W +: C_W]);
      d   = 64'(bt.d[ch*D_W +: D_W]);
      pos = a + c * (64'd1 << DEF_SH_C);
      neg = b * (64'd1 << DEF_SH_B) + d * (64'd1 << DEF_SH_D);
      if (pos < neg) begin
        r.clip[ch] = 1'b1;
        val = 0;
      end else begin
        val = pos - neg;
      end
      if (bt.rnd) val = val + (64'd1 << (DEF_FRAC - 1));
      q = val / (64'd1 << DEF_FRAC);
      if (q > qmax) begin
        r.sat[ch] = 1'b1;
        q = qmax;
      end
      r.data[ch*OUT_W +: OUT_W] = OUT_W'(q);
    end
    return r;
  endfunction

  function automatic logic [63:0] rnd_bits(input int w);
    logic [63:0] v;
    v = {$urandom, $urandom};
    v = v & ((64'd1 << w) - 64'd1);
    return v >> $urandom_range(0, w - 1);
  endfunction

  function automatic beat_t rand_beat();
    beat_t bt;
    for (int ch = 0; ch < CH; ch++) begin
      bt.a[ch*A_W +: A_W] = A_W'(rnd_bits(A_W));
      bt.b[ch*B_W +: B_W] = B_W'(rnd_bits(B_W));
      bt.c[ch*C_W +: C_W] = C_W'(rnd_bits(C_W));
      bt.d[ch*D_W +: D_W] = D_W'(rnd_bits(D_W));
    end
    bt.rnd = 1'($urandom_range(0, 1));
    return bt;
  endfunction

  function automatic beat_t ch0_beat(input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] c, input logic [63:0] d,
                                     input logic rnd);
    beat_t bt;
    bt = '0;
    bt.a[A_W-1:0] = A_W'(a);
    bt.b[B_W-1:0] = B_W'(b);
    bt.c[C_W-1:0] = C_W'(c);
    bt.d[D_W-1:0] = D_W'(d);
    bt.rnd = rnd;
    return bt;
  endfunction

  task automatic drive(input beat_t bt, input logic v);
    bus.in_a     = bt.a;
    bus.in_b     = bt.b;
    bus.in_c     = bt.c;
    bus.in_d     = bt.d;
    bus.in_round = bt.rnd;
    bus.in_valid = v;
  endtask

  // One channel-0 beat with out_ready high: check latency, data and flags,
  // then let it be accepted.
  task automatic single(input string tag, input beat_t bt, input logic [63:0] exp_data,
                        input logic [63:0] exp_clip, input logic [63:0] exp_sat);
    int lat;
    bus.out_ready = 1'b1;
    drive(bt, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    check({tag, " data"}, 64'(bus.out_data), exp_data);
    check({tag, " clip"}, 64'(bus.out_clip), exp_clip);
    check({tag, " sat"}, 64'(bus.out_sat), exp_sat);
    tick();
  endtask

  initial begin
    beat_t bt;
    beat_t cur;
    res_t  e;
    res_t  held;
    res_t  exp_q[$];
    logic  stalled;
    int    sent;
    int    cyc;
    int    lat;

    rst_n     = 1'b0;
    clr_stats = 1'b0;
    bus.out_ready = 1'b1;
    drive('0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("reset out_valid", 64'(bus.out_valid), 0);
    check("reset out_data", 64'(bus.out_data), 0);
    check("reset out_clip", 64'(bus.out_clip), 0);
    check("reset out_sat", 64'(bus.out_sat), 0);
    check("reset in_ready", 64'(bus.in_ready), 1);
    check("reset clip_cnt", 64'(clip_cnt), 0);
    check("reset sat_cnt", 64'(sat_cnt), 0);

    // Basic path, FRAC boundary with and without rounding, clip, saturate
    single("c2a00", ch0_beat(0, 0, 64'h2A00, 0, 1'b0), 42, 0, 0);
    single("half lsb rnd0", ch0_beat(64'h800000, 0, 0, 0, 1'b0), 0, 0, 0);
    single("half lsb rnd1", ch0_beat(64'h800000, 0, 0, 0, 1'b1), 1, 0, 0);
    single("neg b", ch0_beat(0, 1, 0, 0, 1'b0), 0, 1, 0);
    check("clip_cnt after clip", 64'(clip_cnt), 1);
    check("sat_cnt after clip", 64'(sat_cnt), 0);
    single("sat 300", ch0_beat(0, 0, 64'h12C00, 0, 1'b0), 255, 0, 1);
    check("sat_cnt after sat", 64'(sat_cnt), 1);
    check("clip_cnt after sat", 64'(clip_cnt), 1);

    // Counter sticks at all-ones after a long saturating stream
    bt = ch0_beat(0, 0, 64'h12C00, 0, 1'b0);
    drive(bt, 1'b1);
    repeat (70000) tick();
    bus.in_valid = 1'b0;
    repeat (LAT + 4) tick();
    check("sat_cnt sticky", 64'(sat_cnt), 64'hFFFF);
    check("clip_cnt unchanged", 64'(clip_cnt), 1);

    // Clear on the same cycle as an accepted saturating beat
    drive(bt, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("clr beat sat flag", 64'(bus.out_sat), 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("sat_cnt after clr", 64'(sat_cnt), 0);
    check("clip_cnt after clr", 64'(clip_cnt), 0);

    // Randomized stream with random backpressure against the model
    sent    = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    cur     = rand_beat();
    while ((sent < 20 || exp_q.size() > 0) && cyc < 500) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (sent < 20) drive(cur, 1'b1);
      else bus.in_valid = 1'b0;
      #1;
      check("in_ready rule", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
      if (stalled) begin
        check("stall holds valid", 64'(bus.out_valid), 1);
        check("stall holds beat", 64'({bus.out_data, bus.out_clip, bus.out_sat}), 64'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected beat", 64'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          check("rand data", 64'(bus.out_data), 64'(e.data));
          check("rand clip", 64'(bus.out_clip), 64'(e.clip));
          check("rand sat", 64'(bus.out_sat), 64'(e.sat));
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = '{data: bus.out_data, clip: bus.out_clip, sat: bus.out_sat};
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(cur));
        sent++;
        cur = rand_beat();
      end
      tick();
      cyc++;
    end
    check("random beats sent", 64'(sent), 20);
    check("random stream drained", 64'(exp_q.size()), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (LAT + 2) tick();

    // Reset with beats in flight and one on the output
    drive(ch0_beat(0, 0, 64'h12C00, 0, 1'b0), 1'b1);
    repeat (LAT + 1) tick();
    check("pre-reset out_valid", 64'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 64'(bus.out_valid), 0);
    check("mid reset out_data", 64'(bus.out_data), 0);
    check("mid reset out_sat", 64'(bus.out_sat), 0);
    check("mid reset sat_cnt", 64'(sat_cnt), 0);
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    single("post reset", ch0_beat(0, 0, 64'h2A00, 0, 1'b0), 42, 0, 0);
    check("post reset sat_cnt", 64'(sat_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
